// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite bus bundle between one master (or fabric) and one SRAM-backed responder.
// The fabric-level hready is driven from the master side of the bundle.
interface ahbl_sram_slave_if #(
    parameter int unsigned AHBL_ADDR_WIDTH = 32,
    parameter int unsigned AHBL_DATA_WIDTH = 32
);
    logic                       hsel;
    logic [AHBL_ADDR_WIDTH-1:0] haddr;
    logic [1:0]                 htrans;
    logic                       hwrite;
    logic [2:0]                 hsize;
    logic [2:0]                 hburst;
    logic [3:0]                 hprot;
    logic                       hmastlock;
    logic [AHBL_DATA_WIDTH-1:0] hwdata;
    logic                       hready;
    logic                       hreadyout;
    logic                       hresp;
    logic [AHBL_DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder over a word-organised memory with fixed wait states and a
// two-cycle ERROR response for out-of-range, misaligned or oversized accesses.
module ahbl_sram_slave #(
    parameter int unsigned AHBL_ADDR_WIDTH = 32,
    parameter int unsigned AHBL_DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter int unsigned WAIT_STATES     = 0
) (
    input logic              hclk,
    input logic              hresetn,
    ahbl_sram_slave_if.slave bus
);
    localparam int unsigned AW   = AHBL_ADDR_WIDTH;
    localparam int unsigned DW   = AHBL_DATA_WIDTH;
    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW-3:0] DepthLim = (AW-2)'(MEM_DEPTH);
    localparam logic [3:0] WcntLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            write_q, write_d;
    logic [3:0]      strb_q, strb_d;

    logic [DW-1:0]   mem [MEM_DEPTH];

    logic            accept, aligned, legal, readyout, resp, mem_we;
    logic [3:0]      strb_new;

    always_comb begin
        accept = bus.hsel && bus.hready && bus.htrans[1];
        unique case (bus.hsize)
            3'd0: begin
                aligned  = 1'b1;
                strb_new = 4'b0001 << bus.haddr[1:0];
            end
            3'd1: begin
                aligned  = !bus.haddr[0];
                strb_new = bus.haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                aligned  = (bus.haddr[1:0] == 2'b00);
                strb_new = 4'b1111;
            end
            default: begin
                aligned  = 1'b0;
                strb_new = 4'b0000;
            end
        endcase
        legal = aligned && (bus.haddr[AW-1:2] < DepthLim);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        strb_d   = strb_q;
        readyout = 1'b1;
        resp     = 1'b0;

        unique case (state_q)
            StWait: begin
                readyout = 1'b0;
                if (wcnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            StErr1: begin
                readyout = 1'b0;
                resp     = 1'b1;
                state_d  = StErr2;
            end
            StErr2:  resp = 1'b1;
            default: ;
        endcase

        // Idle, Data and Err2 all end on this edge, so a new address phase may be taken.
        if (readyout) begin
            if (accept) begin
                idx_d   = bus.haddr[IdxW+1:2];
                write_d = bus.hwrite;
                strb_d  = strb_new;
                if (!legal) begin
                    state_d = StErr1;
                end else if (WAIT_STATES > 0) begin
                    state_d = StWait;
                    wcnt_d  = WcntLoad;
                end else begin
                    state_d = StData;
                end
            end else begin
                state_d = StIdle;
            end
        end
    end

    assign mem_we = (state_q == StData) && write_q;

    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (strb_q[n]) begin
                    mem[idx_q][8*n +: 8] <= bus.hwdata[8*n +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = readyout;
    assign bus.hresp     = resp;
    assign bus.hrdata    = ((state_q == StData) && !write_q) ? mem[idx_q] : '0;

    logic unused;
    assign unused = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench: four responders with 0..3 wait states share one master model;
// sel picks which one is addressed and which one drives the bus-level ready.
module tb_ahbl_sram_slave;
    localparam logic [1:0] Idle = 2'd0, Busy = 2'd1, Nonseq = 2'd2, Seq = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        rdy, resp;
    logic [31:0] rdata;

    logic [3:0]  rdy_a, resp_a;
    logic [31:0] rdata_a [4];

    int vectors = 0;
    int miscompares = 0;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        ahbl_sram_slave_if #(.AHBL_ADDR_WIDTH(32), .AHBL_DATA_WIDTH(32)) bus ();
        assign bus.hsel      = hsel && (sel == 2'(k));
        assign bus.haddr     = haddr;
        assign bus.htrans    = htrans;
        assign bus.hwrite    = hwrite;
        assign bus.hsize     = hsize;
        assign bus.hburst    = 3'd0;
        assign bus.hprot     = 4'd0;
        assign bus.hmastlock = 1'b0;
        assign bus.hwdata    = hwdata;
        assign bus.hready    = hready;
        assign rdy_a[k]      = bus.hreadyout;
        assign resp_a[k]     = bus.hresp;
        assign rdata_a[k]    = bus.hrdata;

        ahbl_sram_slave #(
            .AHBL_ADDR_WIDTH(32),
            .AHBL_DATA_WIDTH(32),
            .MEM_DEPTH      (1024),
            .WAIT_STATES    (k)
        ) u_dut (
            .hclk   (clk),
            .hresetn(rst_n),
            .bus    (bus.slave)
        );
    end

    assign rdy    = rdy_a[sel];
    assign resp   = resp_a[sel];
    assign rdata  = rdata_a[sel];
    assign hready = rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a);
        hsel   = 1'b1;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        drive(Idle, 1'b0, 3'd2, 32'h0);
    endtask

    // Called right after the accepting edge, with the next address phase already driven.
    task automatic data_phase(input int waits, input logic [31:0] wd, input logic [31:0] exp,
                              input string tag);
        hwdata = wd;
        for (int i = 0; i < waits; i++) begin
            chk({tag, " wait rdy"}, 32'(rdy), 32'd0);
            chk({tag, " wait resp"}, 32'(resp), 32'd0);
            chk({tag, " wait rdata"}, rdata, 32'd0);
            tick();
        end
        chk({tag, " rdy"}, 32'(rdy), 32'd1);
        chk({tag, " resp"}, 32'(resp), 32'd0);
        chk({tag, " rdata"}, rdata, exp);
        tick();
    endtask

    task automatic err_phase(input string tag);
        hwdata = 32'hBAD0BAD0;
        chk({tag, " err1 rdy"}, 32'(rdy), 32'd0);
        chk({tag, " err1 resp"}, 32'(resp), 32'd1);
        chk({tag, " err1 rdata"}, rdata, 32'd0);
        tick();
        chk({tag, " err2 rdy"}, 32'(rdy), 32'd1);
        chk({tag, " err2 resp"}, 32'(resp), 32'd1);
        chk({tag, " err2 rdata"}, rdata, 32'd0);
        tick();
    endtask

    task automatic single_wr(input int waits, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input string tag);
        drive(Nonseq, 1'b1, sz, a);
        tick();
        idle();
        data_phase(waits, wd, 32'd0, tag);
    endtask

    task automatic single_rd(input int waits, input logic [31:0] a, input logic [31:0] exp,
                             input string tag);
        drive(Nonseq, 1'b0, 3'd2, a);
        tick();
        idle();
        data_phase(waits, 32'h0, exp, tag);
    endtask

    task automatic bad_wr(input logic [2:0] sz, input logic [31:0] a, input string tag);
        drive(Nonseq, 1'b1, sz, a);
        tick();
        idle();
        err_phase(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        sel    = 2'd0;
        hwdata = 32'h0;
        idle();
        #2;
        chk("reset rdy", 32'(rdy), 32'd1);
        chk("reset resp", 32'(resp), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Zero wait states: write then read pipelined back-to-back
        sel = 2'd0;
        drive(Nonseq, 1'b1, 3'd2, 32'h10);
        tick();
        drive(Nonseq, 1'b0, 3'd2, 32'h10);
        data_phase(0, 32'hDEADBEEF, 32'd0, "b2b wr");
        idle();
        data_phase(0, 32'h0, 32'hDEADBEEF, "b2b rd");
        chk("idle rdata", rdata, 32'd0);

        // Byte and halfword lanes
        single_wr(0, 3'd2, 32'h20, 32'h00000000, "lane w0");
        single_wr(0, 3'd0, 32'h21, 32'h0000AA00, "lane b1");
        single_wr(0, 3'd1, 32'h22, 32'h12340000, "lane h1");
        single_rd(0, 32'h20, 32'h1234AA00, "lane rd");
        single_wr(0, 3'd2, 32'h30, 32'hFFFFFFFF, "lane w1");
        single_wr(0, 3'd0, 32'h33, 32'h00000000, "lane b3");
        single_wr(0, 3'd1, 32'h30, 32'h00005566, "lane h0");
        single_rd(0, 32'h30, 32'h00FF5566, "lane rd2");

        // Two wait states
        sel = 2'd2;
        single_wr(2, 3'd2, 32'h40, 32'hCAFEF00D, "ws2 wr");
        single_rd(2, 32'h40, 32'hCAFEF00D, "ws2 rd");

        // Illegal accesses leave word 0 untouched
        sel = 2'd0;
        single_wr(0, 3'd2, 32'h0, 32'h11223344, "err seed");
        bad_wr(3'd2, 32'h1000, "err range");
        bad_wr(3'd2, 32'h2, "err align");
        bad_wr(3'd3, 32'h0, "err size");
        single_rd(0, 32'h0, 32'h11223344, "err rd");
        // Error immediately followed by a legal beat accepted on the ERR2 edge
        drive(Nonseq, 1'b1, 3'd1, 32'h1);
        tick();
        hwdata = 32'hBAD0BAD0;
        chk("err pipe err1 rdy", 32'(rdy), 32'd0);
        tick();
        drive(Nonseq, 1'b0, 3'd2, 32'h0);
        chk("err pipe err2 resp", 32'(resp), 32'd1);
        tick();
        idle();
        data_phase(0, 32'h0, 32'h11223344, "err pipe rd");

        // INCR4 write burst with one BUSY cycle, one wait state
        sel = 2'd1;
        drive(Nonseq, 1'b1, 3'd2, 32'h60);
        tick();
        drive(Seq, 1'b1, 3'd2, 32'h64);
        data_phase(1, 32'hA0A0A0A0, 32'd0, "burst b0");
        drive(Busy, 1'b1, 3'd2, 32'h68);
        data_phase(1, 32'hB1B1B1B1, 32'd0, "burst b1");
        drive(Seq, 1'b1, 3'd2, 32'h68);
        chk("burst busy rdy", 32'(rdy), 32'd1);
        chk("burst busy resp", 32'(resp), 32'd0);
        tick();
        drive(Seq, 1'b1, 3'd2, 32'h6C);
        data_phase(1, 32'hC2C2C2C2, 32'd0, "burst b2");
        idle();
        data_phase(1, 32'hD3D3D3D3, 32'd0, "burst b3");
        single_rd(1, 32'h60, 32'hA0A0A0A0, "burst rd0");
        single_rd(1, 32'h64, 32'hB1B1B1B1, "burst rd1");
        single_rd(1, 32'h68, 32'hC2C2C2C2, "burst rd2");
        single_rd(1, 32'h6C, 32'hD3D3D3D3, "burst rd3");

        // Reset asserted in the middle of a three-wait-state write
        sel = 2'd3;
        single_wr(3, 3'd2, 32'h50, 32'h55AA55AA, "rst seed");
        drive(Nonseq, 1'b1, 3'd2, 32'h50);
        tick();
        idle();
        hwdata = 32'h0BADCAFE;
        chk("rst pre rdy", 32'(rdy), 32'd0);
        tick();
        chk("rst pre rdy2", 32'(rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst async rdy", 32'(rdy), 32'd1);
        chk("rst async resp", 32'(resp), 32'd0);
        chk("rst async rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst post rdy", 32'(rdy), 32'd1);
        single_rd(3, 32'h50, 32'h55AA55AA, "rst rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahbl_sram_slave.md
# ahbl_sram_slave

AHB-Lite responder (subordinate) backed by a word-organised internal memory, with a programmable number of wait states and two-cycle ERROR responses for illegal accesses. It sits on the slave side of the AHB-Lite fabric and serves as the DUT/reference target for the AHB-Lite master agent. It also serves as a behavioural memory model in subsystem benches.

## Interface
- AHBL_ADDR_WIDTH, 32, HADDR width.
- AHBL_DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 is supported.
- MEM_DEPTH, 1024, memory size in 32-bit words; byte range 0 to 4*MEM_DEPTH-1.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before each OKAY completion; range 0..15.
- HCLK  in  1  clock; all logic on the rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  AHBL_ADDR_WIDTH  byte address.
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 halfword, 2 word; values 3 and above are illegal.
- HBURST  in  3  ignored; each beat is handled on its own.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  AHBL_DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; an address phase is sampled only when it is 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  AHBL_DATA_WIDTH  read data.

## Operation
- Address phase accepted on a rising edge with HSEL=1, HREADY=1, HTRANS[1]=1. At that edge the block latches addr, write, size and a legal flag.
- IDLE or BUSY, or HSEL=0, with HREADY=1: nothing is latched. The next cycle gives a zero-wait OKAY.
- legal = (HSIZE <= 2) and (HADDR aligned to the size) and (HADDR[AW-1:2] < MEM_DEPTH).
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0.
  - On an accepted legal transfer: go to WAIT if WAIT_STATES>0, otherwise stay on the DATA path. Load wcnt=WAIT_STATES-1.
  - WAIT: HREADYOUT=0, HRESP=0. wcnt decrements each cycle; at wcnt=0 go to DATA.
  - DATA: one cycle, HREADYOUT=1, HRESP=0. Completes the beat. A new address phase may be accepted on the same edge.
  - On an accepted illegal transfer: go to ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE or a newly accepted transfer.
  - With WAIT_STATES=0, a legal beat's data phase is one cycle with HREADYOUT=1.
- Writes:
  - Commit at the edge that ends the data phase (HREADYOUT=1, HRESP=0).
  - Only the byte lanes selected by size and addr[1:0] are written. Little-endian: byte lane n = HWDATA[8n+7:8n].
  - Halfword at addr[1]=1 uses lanes 3:2.
- Reads:
  - During a read data phase, HRDATA = full word mem[addr[AW-1:2]]. All lanes are driven.
  - HRDATA must reflect any write committed on an earlier edge, including the immediately preceding beat.
  - Outside read data phases and during ERROR, HRDATA=0.
- Illegal transfers never modify memory.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0. State is IDLE and wcnt=0.
- Reset asserted mid-transfer: the transfer is aborted immediately and no write is committed. Outputs return to the reset values asynchronously.
- Latency from address-phase edge to completing edge: WAIT_STATES+1 cycles for legal beats, 2 cycles for ERROR.
- While HREADYOUT=0, no new address phase is sampled; HREADY is low on the bus at that time.
- Back-to-back pipelining: the address phase of beat N+1 is sampled on the same edge that completes beat N.
- HRESP may change only while HREADYOUT=0 or on entry to a new data phase. The ERROR response must always be the two-cycle sequence.
- BUSY in the middle of a burst gets a zero-wait OKAY and causes no state change.

## Test plan
- Reset: drive HRESETn=0 mid-WAIT with WAIT_STATES=3 -> HREADYOUT=1, HRESP=0 and HRDATA=0 immediately. The pending write's word keeps its old value.
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> each beat completes in 1 cycle and HRDATA=0xDEADBEEF in the read data phase.
- Byte/halfword lanes: write word 0x00000000 to 0x20, then byte 0xAA at 0x21 (HWDATA=0x0000AA00), then halfword 0x1234 at 0x22 (HWDATA=0x12340000) -> a read of 0x20 returns 0x1234AA00.
- WAIT_STATES=2: single read -> HREADYOUT sequence 0,0,1 with HRESP=0 throughout, and the data is valid in the third cycle.
- Errors:
  - Write to byte address 4*MEM_DEPTH -> HREADYOUT/HRESP = 0/1, then 1/1.
  - Word write at 0x02 (misaligned) -> the same two-cycle ERROR.
  - HSIZE=3 -> the same two-cycle ERROR.
  - In all three cases a later read of word 0 returns its previous contents unchanged.
- INCR4 burst with one BUSY cycle inserted, WAIT_STATES=1 -> 4 beats each with one wait cycle. The BUSY cycle gives a zero-wait OKAY, and all 4 words read back correctly.
